// File: rtl/gray_ptr_fifo_ctrl_if.sv
// gray_ptr_fifo_ctrl_if: request/status bundle between a FIFO user and the Gray-pointer controller.
interface gray_ptr_fifo_ctrl_if #(parameter int ADDR_W = 4);
  logic wr_en, rd_en, wr_accept, rd_accept;
  logic full, empty, almost_full, overflow, underflow;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0] wr_ptr_gray, rd_ptr_gray, count;
  modport master(
    output wr_en, rd_en,
    input wr_addr, rd_addr, wr_accept, rd_accept, wr_ptr_gray, rd_ptr_gray,
    input full, empty, almost_full, count, overflow, underflow
  );
  modport slave(
    input wr_en, rd_en,
    output wr_addr, rd_addr, wr_accept, rd_accept, wr_ptr_gray, rd_ptr_gray,
    output full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/gray_ptr_fifo_ctrl.sv
// gray_ptr_fifo_ctrl: single-clock FIFO pointer controller with Gray-coded pointers and registered status.
module gray_ptr_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int AF_LEVEL = 12
) (
  input logic clk,
  input logic rst_n,
  gray_ptr_fifo_ctrl_if.slave bus
);
  // full when the two top Gray bits differ and the rest match; also covers ADDR_W=1
  localparam logic [ADDR_W:0] FULL_MASK = (ADDR_W+1)'(3) << (ADDR_W-1);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_LEVEL);
  logic [ADDR_W:0] wb, rb, wb_n, rb_n, ng_w, ng_r, cnt_n;
  logic wa, ra;
  assign wa = bus.wr_en & ~bus.full;
  assign ra = bus.rd_en & ~bus.empty;
  assign bus.wr_accept = wa;
  assign bus.rd_accept = ra;
  assign bus.wr_addr = wb[ADDR_W-1:0];
  assign bus.rd_addr = rb[ADDR_W-1:0];
  always_comb begin
    wb_n = wb + (ADDR_W+1)'(wa);
    rb_n = rb + (ADDR_W+1)'(ra);
    ng_w = wb_n ^ (wb_n >> 1);
    ng_r = rb_n ^ (rb_n >> 1);
    cnt_n = wb_n - rb_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb <= '0;
      rb <= '0;
      bus.wr_ptr_gray <= '0;
      bus.rd_ptr_gray <= '0;
      bus.count <= '0;
      bus.empty <= 1'b1;
      bus.full <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      wb <= wb_n;
      rb <= rb_n;
      bus.wr_ptr_gray <= ng_w;
      bus.rd_ptr_gray <= ng_r;
      bus.count <= cnt_n;
      bus.empty <= ng_w == ng_r;
      bus.full <= ng_w == (ng_r ^ FULL_MASK);
      bus.almost_full <= cnt_n >= AF;
      bus.overflow <= bus.wr_en & bus.full;
      bus.underflow <= bus.rd_en & bus.empty;
    end
  end
endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// tb_gray_ptr_fifo_ctrl: randomized and directed scoreboard bench against an occupancy/index model.
module tb_gray_ptr_fifo_ctrl;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;
  localparam int AFL = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  gray_ptr_fifo_ctrl_if #(.ADDR_W(AW)) bus();
  gray_ptr_fifo_ctrl #(.ADDR_W(AW), .AF_LEVEL(AFL)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int wa, ra, waddr, raddr, wg, rg, full, empty, af, cnt, ovf, unf;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_wr = 0, m_rd = 0;
  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit rst, input bit we, input bit re);
    exp_t e;
    int occ;
    @(negedge clk);
    rst_n = ~rst;
    bus.wr_en = we;
    bus.rd_en = re;
    #1;
    occ = m_wr - m_rd;
    e.wa = int'(we && occ != DEPTH);
    e.ra = int'(re && occ != 0);
    e.waddr = m_wr % DEPTH;
    e.raddr = m_rd % DEPTH;
    if (rst) begin
      m_wr = 0;
      m_rd = 0;
      e.ovf = 0;
      e.unf = 0;
    end else begin
      e.ovf = int'(we && occ == DEPTH);
      e.unf = int'(re && occ == 0);
      m_wr += e.wa;
      m_rd += e.ra;
    end
    occ = m_wr - m_rd;
    e.wg = gray(m_wr % (2 * DEPTH));
    e.rg = gray(m_rd % (2 * DEPTH));
    e.cnt = occ;
    e.full = int'(occ == DEPTH);
    e.empty = int'(occ == 0);
    e.af = int'(occ >= AFL);
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    int pw = 0, pr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wr_accept", int'(bus.wr_accept), e.wa);
        chk("rd_accept", int'(bus.rd_accept), e.ra);
        chk("wr_addr", int'(bus.wr_addr), e.waddr);
        chk("rd_addr", int'(bus.rd_addr), e.raddr);
        @(posedge clk);
        #1;
        chk("wr_ptr_gray", int'(bus.wr_ptr_gray), e.wg);
        chk("rd_ptr_gray", int'(bus.rd_ptr_gray), e.rg);
        chk("count", int'(bus.count), e.cnt);
        chk("full", int'(bus.full), e.full);
        chk("empty", int'(bus.empty), e.empty);
        chk("almost_full", int'(bus.almost_full), e.af);
        chk("overflow", int'(bus.overflow), e.ovf);
        chk("underflow", int'(bus.underflow), e.unf);
        if (e.wg != 0) chk("wr_gray_one_bit_step", $countones(bus.wr_ptr_gray ^ 3'(pw)) <= 1 ? 1 : 0, 1);
        if (e.rg != 0) chk("rd_gray_one_bit_step", $countones(bus.rd_ptr_gray ^ 3'(pr)) <= 1 ? 1 : 0, 1);
        pw = e.wg;
        pr = e.rg;
      end
    end
  end
  initial begin
    bus.wr_en = 0;
    bus.rd_en = 0;
    repeat (2) @(posedge clk);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    repeat (5) cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 1);
    repeat (2) cyc(0, 1, 0);
    repeat (2) cyc(0, 1, 1);
    repeat (2) cyc(0, 0, 1);
    cyc(0, 1, 1);
    repeat (4) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (4) cyc(0, 0, 1);
    repeat (20) begin
      cyc(0, 1, 0);
      cyc(0, 0, 1);
    end
    repeat (3) cyc(0, 1, 0);
    cyc(1, 1, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50);
    for (int i = 0; i < 400; i++)
      cyc(0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
